fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL expose parameter: RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] ignored).
REQ-002 SHALL expose parameter: BUF_DEPTH, 2, instruction buffer entries; legal values 2 only.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: imem_req  output  1  fetch request valid.
REQ-006 SHALL have port: imem_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port: imem_gnt  input  1  request accepted when imem_req && imem_gnt at clock edge.
REQ-008 SHALL have port: imem_rvalid  input  1  response valid; responses return in request order, at least 1 cycle after grant.
REQ-009 SHALL have port: imem_rdata  input  32  response instruction word.
REQ-010 SHALL have port: branch_taken  input  1  redirect strobe from later stage.
REQ-011 SHALL have port: branch_target  input  32  redirect address.
REQ-012 SHALL have port: instr_valid  output  1  instr/pc_plus4/rs/rt/rd valid to decode.
REQ-013 SHALL have port: instr_ready  input  1  decode accepts head entry when instr_valid && instr_ready.
REQ-014 SHALL have ports: instr  output  32; pc_plus4  output  32; rs/rt/rd  output  5 each = instr[25:21]/[20:16]/[15:11].

Function
REQ-015 SHALL implement states BOOT, FETCH, DRAIN; BOOT -> FETCH unconditionally one cycle after reset release.
REQ-016 SHALL assert imem_req only in FETCH, and only when buffer_count + outstanding < 2.
REQ-017 SHALL advance pc by 4 (modulo 2^32, wrap 32'hFFFF_FFFC -> 0) on each grant; increment outstanding on grant, decrement on rvalid.
REQ-018 SHALL write {imem_rdata, addr+4} into buffer tail on a non-discarded rvalid; data visible at outputs the cycle after rvalid (no bypass).
REQ-019 SHALL pop the head on instr_valid && instr_ready; simultaneous push and pop SHALL keep count unchanged.
REQ-020 SHALL drive instr=0, pc_plus4=0, rs/rt/rd=0 whenever buffer empty (instr_valid=0).
REQ-021 SHALL, on branch_taken: flush buffer (instr_valid=0 next cycle), load pc = {branch_target[31:2],2'b00}, mark all outstanding responses as discard; go to DRAIN if outstanding (after this edge) > 0, else FETCH.
REQ-022 SHALL, in DRAIN, drop every rvalid without writing the buffer and issue no requests; DRAIN -> FETCH when discard count reaches 0.
REQ-023 SHALL give branch_taken priority over a same-cycle pop, push, or grant: popped entry consumed, pushed/granted response discarded, pc = target.
REQ-024 SHALL accept branch_taken in DRAIN: pc reloaded, state stays DRAIN.
REQ-025 SHALL ignore imem_rvalid when outstanding = 0 (protocol error, no state change).

Reset
REQ-026 SHALL on rst_n=0 immediately set: state BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, pc_plus4=0, buffer count 0, outstanding 0, discard 0.
REQ-027 SHALL discard any response arriving after reset, even for a request granted before it.

Configuration
REQ-028 SHALL, with FETCH_STALLCNT_EN defined, add output stall_cnt (32) counting cycles with state FETCH and instr_valid=0, saturating at 32'hFFFF_FFFF, cleared by reset.
REQ-029 SHALL, without FETCH_STALLCNT_EN, omit the stall_cnt port and its logic entirely.

Verification
REQ-030 SHALL cover reset, gnt=1, rvalid 1 cycle after grant, ready=1 -> addresses 0,4,8...; first instr_valid 3 cycles after rst_n rises; pc_plus4=4,8,12.
REQ-031 SHALL cover ready=0 for 10 cycles -> buffer fills to 2, imem_req=0, no lost/duplicated words after ready=1.
REQ-032 SHALL cover branch_taken with target 32'h0000_0103 while 2 outstanding -> DRAIN, both responses dropped, next imem_addr=32'h0000_0100.
REQ-033 SHALL cover RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-034 SHALL cover branch_taken coincident with rvalid and pop -> popped entry consumed once, rvalid word never appears at instr.
REQ-035 SHALL cover rst_n asserted mid-stream with 1 outstanding -> all outputs at reset values same cycle; late rvalid ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests words from instruction memory, queues them in a
// two-entry buffer for decode, and handles branch redirects. Define FETCH_STALLCNT_EN to add the stall_cnt output.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd
`ifdef FETCH_STALLCNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [2:0]  DEPTH    = 3'(BUF_DEPTH);
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state_r, state_nxt_s;
  logic [31:0] pc_r, pc_nxt_s;
  logic [1:0]  out_r, out_nxt_s;
  logic [1:0]  disc_r, disc_nxt_s;
  logic [1:0]  cnt_r, cnt_nxt_s;
  logic [31:0] head_instr_r, head_instr_nxt_s;
  logic [31:0] head_pc4_r, head_pc4_nxt_s;
  logic [31:0] tail_instr_r, tail_instr_nxt_s;
  logic [31:0] tail_pc4_r, tail_pc4_nxt_s;
  logic        req_r, req_nxt_s;
  logic        valid_r;

  logic        grant_s, acc_s, pop_s, push_s;
  logic [31:0] resp_pc4_s;
  logic        unused_tgt_s;

  assign grant_s = req_r & imem_gnt;
  // A response is only meaningful while something is outstanding.
  assign acc_s   = imem_rvalid & (out_r != 2'd0);
  assign pop_s   = valid_r & instr_ready;
  assign push_s  = acc_s & (disc_r == 2'd0) & (state_r == FETCH) & ~branch_taken;
  // Oldest live response belongs to address pc - 4*outstanding.
  assign resp_pc4_s   = pc_r - {28'd0, out_r, 2'b00} + 32'd4;
  assign unused_tgt_s = ^branch_target[1:0];

  // Next-state computation for counters, pc, FSM and the buffer.
  always_comb begin
    out_nxt_s        = out_r + {1'b0, grant_s} - {1'b0, acc_s};
    pc_nxt_s         = pc_r;
    disc_nxt_s       = disc_r;
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    head_instr_nxt_s = head_instr_r;
    head_pc4_nxt_s   = head_pc4_r;
    tail_instr_nxt_s = tail_instr_r;
    tail_pc4_nxt_s   = tail_pc4_r;

    if (branch_taken) begin
      pc_nxt_s   = {branch_target[31:2], 2'b00};
      disc_nxt_s = out_nxt_s;
    end else begin
      if (grant_s) begin
        pc_nxt_s = pc_r + 32'd4;
      end else begin
        pc_nxt_s = pc_r;
      end
      if (acc_s && (disc_r != 2'd0)) begin
        disc_nxt_s = disc_r - 2'd1;
      end else begin
        disc_nxt_s = disc_r;
      end
    end

    case (state_r)
      BOOT:  state_nxt_s = FETCH;
      FETCH: begin
        if (branch_taken && (out_nxt_s != 2'd0)) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      DRAIN: begin
        if (branch_taken) begin
          state_nxt_s = DRAIN;
        end else if (disc_nxt_s == 2'd0) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = BOOT;
    endcase

    // Head entry is kept zero while the buffer is empty so outputs read as 0.
    if (branch_taken) begin
      cnt_nxt_s        = 2'd0;
      head_instr_nxt_s = 32'd0;
      head_pc4_nxt_s   = 32'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          cnt_nxt_s = cnt_r + 2'd1;
          if (cnt_r == 2'd0) begin
            head_instr_nxt_s = imem_rdata;
            head_pc4_nxt_s   = resp_pc4_s;
          end else begin
            tail_instr_nxt_s = imem_rdata;
            tail_pc4_nxt_s   = resp_pc4_s;
          end
        end
        2'b01: begin
          cnt_nxt_s = cnt_r - 2'd1;
          if (cnt_r == 2'd2) begin
            head_instr_nxt_s = tail_instr_r;
            head_pc4_nxt_s   = tail_pc4_r;
          end else begin
            head_instr_nxt_s = 32'd0;
            head_pc4_nxt_s   = 32'd0;
          end
        end
        2'b11: begin
          if (cnt_r == 2'd2) begin
            head_instr_nxt_s = tail_instr_r;
            head_pc4_nxt_s   = tail_pc4_r;
            tail_instr_nxt_s = imem_rdata;
            tail_pc4_nxt_s   = resp_pc4_s;
          end else begin
            head_instr_nxt_s = imem_rdata;
            head_pc4_nxt_s   = resp_pc4_s;
          end
        end
        default: cnt_nxt_s = cnt_r;
      endcase
    end

    req_nxt_s = (state_nxt_s == FETCH) &&
                (({1'b0, cnt_nxt_s} + {1'b0, out_nxt_s}) < DEPTH);
  end

  // State, buffer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= BOOT;
      pc_r         <= RESET_PC_ALIGNED;
      out_r        <= 2'd0;
      disc_r       <= 2'd0;
      cnt_r        <= 2'd0;
      head_instr_r <= 32'd0;
      head_pc4_r   <= 32'd0;
      tail_instr_r <= 32'd0;
      tail_pc4_r   <= 32'd0;
      req_r        <= 1'b0;
      valid_r      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      out_r        <= out_nxt_s;
      disc_r       <= disc_nxt_s;
      cnt_r        <= cnt_nxt_s;
      head_instr_r <= head_instr_nxt_s;
      head_pc4_r   <= head_pc4_nxt_s;
      tail_instr_r <= tail_instr_nxt_s;
      tail_pc4_r   <= tail_pc4_nxt_s;
      req_r        <= req_nxt_s;
      valid_r      <= (cnt_nxt_s != 2'd0);
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign instr_valid = valid_r;
  assign instr       = head_instr_r;
  assign pc_plus4    = head_pc4_r;
  assign rs          = head_instr_r[25:21];
  assign rt          = head_instr_r[20:16];
  assign rd          = head_instr_r[15:11];

`ifdef FETCH_STALLCNT_EN
  logic [31:0] stall_r;

  // Saturating count of FETCH cycles with nothing offered to decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_r <= 32'd0;
    end else if ((state_r == FETCH) && !valid_r && (stall_r != 32'hFFFF_FFFF)) begin
      stall_r <= stall_r + 32'd1;
    end else begin
      stall_r <= stall_r;
    end
  end

  assign stall_cnt = stall_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for the streaming case and
// hand-written sequences for stall, branch/drain, reset and pc wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, imem_req, imem_gnt, imem_rvalid, branch_taken, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, branch_target, instr, pc_plus4;
  logic [4:0]  rs, rt, rd;

  logic        w_rst_n, w_req, w_gnt, w_rvalid, w_valid, w_ready;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc4;
  logic [4:0]  w_rs, w_rt, w_rd;

`ifdef FETCH_STALLCNT_EN
  logic [31:0] stall_cnt, w_stall_cnt;
`endif

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .pc_plus4(pc_plus4), .rs(rs), .rt(rt), .rd(rd)
`ifdef FETCH_STALLCNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst_n(w_rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(w_gnt), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .branch_taken(1'b0), .branch_target(32'd0),
    .instr_valid(w_valid), .instr_ready(w_ready), .instr(w_instr),
    .pc_plus4(w_pc4), .rs(w_rs), .rt(w_rt), .rd(w_rd)
`ifdef FETCH_STALLCNT_EN
    , .stall_cnt(w_stall_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] I0 = 32'h0062_2820;
  localparam logic [31:0] I1 = 32'h8C43_0004;
  localparam logic [31:0] I2 = 32'hAC85_0008;
  localparam logic [31:0] I3 = 32'h1234_5678;
  localparam logic [31:0] I4 = 32'h2108_FFFF;
  localparam logic [31:0] I5 = 32'h0000_0020;

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic r, input logic [31:0] a,
                            input logic v, input logic [31:0] i, input logic [31:0] p);
    logic [31:0] ei;
    ei = i;
    chk({tag, " imem_req"},    {31'd0, imem_req},    {31'd0, r});
    chk({tag, " imem_addr"},   imem_addr,            a);
    chk({tag, " instr_valid"}, {31'd0, instr_valid}, {31'd0, v});
    chk({tag, " instr"},       instr,                ei);
    chk({tag, " pc_plus4"},    pc_plus4,             p);
    chk({tag, " rs/rt/rd"},    {17'd0, rs, rt, rd},  {17'd0, ei[25:21], ei[20:16], ei[15:11]});
  endtask

  task automatic drive(input logic g, input logic rv, input logic [31:0] rdat,
                       input logic rdy, input logic br, input logic [31:0] tg);
    @(negedge clk);
    imem_gnt      = g;
    imem_rvalid   = rv;
    imem_rdata    = rdat;
    instr_ready   = rdy;
    branch_taken  = br;
    branch_target = tg;
    @(posedge clk);
    #1;
  endtask

  task automatic wdrive(input logic g, input logic rv, input logic [31:0] rdat, input logic rdy);
    @(negedge clk);
    w_gnt    = g;
    w_rvalid = rv;
    w_rdata  = rdat;
    w_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    instr_ready = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    w_rst_n = 1'b0; w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = 32'd0; w_ready = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0, 32'd0};
    vecs[1] = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0, 32'd0};
    vecs[2] = '{1'b1, 1'b1, I0,    1'b1, 1'b0, 32'd8,  1'b1, I0,    32'd4};
    vecs[3] = '{1'b1, 1'b1, I1,    1'b1, 1'b1, 32'd8,  1'b1, I1,    32'd8};
    vecs[4] = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'd12, 1'b0, 32'd0, 32'd0};
    vecs[5] = '{1'b1, 1'b1, I2,    1'b1, 1'b0, 32'd16, 1'b1, I2,    32'd12};

    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    chk("wrap reset addr", w_addr, 32'hFFFF_FFF8);
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++) begin
      drive(vecs[k].gnt, vecs[k].rvalid, vecs[k].rdata, vecs[k].ready, 1'b0, 32'd0);
      expect_out($sformatf("stream[%0d]", k), vecs[k].req, vecs[k].addr,
                 vecs[k].valid, vecs[k].instr, vecs[k].pc4);
    end

    // Decode stalls for 10 cycles: buffer fills, requests stop.
    drive(1'b1, 1'b1, I3, 1'b0, 1'b0, 32'd0);
    expect_out("fill", 1'b0, 32'd16, 1'b1, I2, 32'd12);
    repeat (9) drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    expect_out("stalled", 1'b0, 32'd16, 1'b1, I2, 32'd12);
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    expect_out("unstall pop1", 1'b1, 32'd16, 1'b1, I3, 32'd16);
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    expect_out("unstall pop2", 1'b1, 32'd20, 1'b0, 32'd0, 32'd0);

    // Branch with two responses outstanding.
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    expect_out("two outstanding", 1'b0, 32'd24, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0103);
    expect_out("branch", 1'b0, 32'h100, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b1, 32'hDEAD_0001, 1'b1, 1'b0, 32'd0);
    expect_out("drain1", 1'b0, 32'h100, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b1, 32'hDEAD_0002, 1'b1, 1'b0, 32'd0);
    expect_out("drain2", 1'b1, 32'h100, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    expect_out("refetch", 1'b1, 32'h104, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b1, I4, 1'b1, 1'b0, 32'd0);
    expect_out("target word", 1'b0, 32'h108, 1'b1, I4, 32'h104);

    // Branch together with rvalid and pop.
    drive(1'b1, 1'b1, 32'hDEAD_0003, 1'b1, 1'b1, 32'h0000_0200);
    expect_out("branch+rvalid+pop", 1'b1, 32'h200, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    expect_out("after branch", 1'b1, 32'h204, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b1, I5, 1'b1, 1'b0, 32'd0);
    expect_out("branch2 word", 1'b0, 32'h208, 1'b1, I5, 32'h204);

    // Reset mid-stream with one response outstanding.
    #2;
    rst_n = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_0004;
    #1;
    expect_out("mid reset", 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 32'hDEAD_0005, 1'b1, 1'b0, 32'd0);
    expect_out("late rvalid boot", 1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 1'b1, 32'hDEAD_0006, 1'b1, 1'b0, 32'd0);
    expect_out("late rvalid fetch", 1'b1, 32'd0, 1'b0, 32'd0, 32'd0);

    // Fetch address wrap from RESET_PC = FFFF_FFF8.
    w_rst_n = 1'b1;
    wdrive(1'b1, 1'b0, 32'd0, 1'b1);
    chk("wrap req1", {31'd0, w_req}, 32'd1);
    chk("wrap addr1", w_addr, 32'hFFFF_FFF8);
    wdrive(1'b1, 1'b0, 32'd0, 1'b1);
    chk("wrap addr2", w_addr, 32'hFFFF_FFFC);
    wdrive(1'b1, 1'b1, I0, 1'b1);
    chk("wrap addr3", w_addr, 32'h0000_0000);
    chk("wrap valid3", {31'd0, w_valid}, 32'd1);
    chk("wrap pc4 3", w_pc4, 32'hFFFF_FFFC);
    wdrive(1'b1, 1'b1, I1, 1'b1);
    chk("wrap instr4", w_instr, I1);
    chk("wrap pc4 4", w_pc4, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
